stopwatch_counter: RTL and testbench

//   BCD mm:ss stopwatch counter clocked by the 1 kHz system tick. Drives the 4-digit 7-segment

---
 rtl/stopwatch_counter.sv | 160 ++++++++++++++++
 tb/tb_stopwatch_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch for the 1 kHz system tick, driving the 4-digit 7-segment mux.
// Run/pause, clear, and manual adjust of the minutes or seconds field.
module stopwatch_counter #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int ADJ_TICKS     = 500
) (
    input  logic       clk1KHz,
    input  logic       rst,
    input  logic       pause,
    input  logic       clear,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       running,
    output logic       sec_tick
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        ADJUST  = 2'd2
    } state_t;

    localparam logic [15:0] SEC_LAST = 16'(TICKS_PER_SEC - 1);
    localparam logic [15:0] ADJ_LAST = 16'(ADJ_TICKS - 1);

    state_t      state, state_n;
    logic [15:0] prescaler, prescaler_n;
    logic [3:0]  m10, m1, s10, s1;
    logic [3:0]  m10_n, m1_n, s10_n, s1_n;
    logic        sec_tick_n;
    logic        sel_q;
    logic [7:0]  sec_next, min_next;

    // Steps a tens:ones BCD pair through 00..59, wrapping 59 -> 00.
    // Out-of-range codes are treated as their maximum so the pair always recovers.
    function automatic logic [7:0] inc60(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] result;
        if (ones >= 4'd9) begin
            if (tens >= 4'd5)
                result = 8'h00;
            else
                result = {tens + 4'd1, 4'd0};
        end else begin
            result = {tens, ones + 4'd1};
        end
        return result;
    endfunction

    assign sec_next = inc60(s10, s1);
    assign min_next = inc60(m10, m1);

    always_ff @(posedge clk1KHz or posedge rst) begin
        if (rst) begin
            state     <= STOPPED;
            prescaler <= '0;
            m10       <= '0;
            m1        <= '0;
            s10       <= '0;
            s1        <= '0;
            sec_tick  <= 1'b0;
            running   <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state     <= state_n;
            prescaler <= prescaler_n;
            m10       <= m10_n;
            m1        <= m1_n;
            s10       <= s10_n;
            s1        <= s1_n;
            sec_tick  <= sec_tick_n;
            running   <= (state_n == RUNNING);
            sel_q     <= sel;
        end
    end

    // Per-cycle priority is clear > adj > pause > terminal tick.
    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        m10_n       = m10;
        m1_n        = m1;
        s10_n       = s10;
        s1_n        = s1;
        sec_tick_n  = 1'b0;

        if (clear) begin
            m10_n       = 4'd0;
            m1_n        = 4'd0;
            s10_n       = 4'd0;
            s1_n        = 4'd0;
            prescaler_n = '0;
            state_n     = adj ? ADJUST : STOPPED;
        end else begin
            case (state)
                STOPPED: begin
                    prescaler_n = '0;
                    if (adj)
                        state_n = ADJUST;
                    else if (pause)
                        state_n = RUNNING;
                end

                RUNNING: begin
                    if (adj) begin
                        state_n     = ADJUST;
                        prescaler_n = '0;
                    end else begin
                        if (prescaler == SEC_LAST) begin
                            prescaler_n   = '0;
                            sec_tick_n    = 1'b1;
                            {s10_n, s1_n} = sec_next;
                            if (sec_next == 8'h00)
                                {m10_n, m1_n} = min_next;
                        end else begin
                            prescaler_n = prescaler + 16'd1;
                        end
                        // A pause on the terminal cycle still keeps that second.
                        if (pause) begin
                            state_n     = STOPPED;
                            prescaler_n = '0;
                        end
                    end
                end

                ADJUST: begin
                    if (!adj) begin
                        state_n     = STOPPED;
                        prescaler_n = '0;
                    end else if (sel != sel_q) begin
                        prescaler_n = '0;
                    end else if (prescaler == ADJ_LAST) begin
                        prescaler_n = '0;
                        sec_tick_n  = 1'b1;
                        if (sel)
                            {s10_n, s1_n} = sec_next;
                        else
                            {m10_n, m1_n} = min_next;
                    end else begin
                        prescaler_n = prescaler + 16'd1;
                    end
                end

                default: begin
                    state_n     = STOPPED;
                    prescaler_n = '0;
                end
            endcase
        end
    end

    assign digit1 = m10;
    assign digit2 = m1;
    assign digit3 = s10;
    assign digit4 = s1;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter with TICKS_PER_SEC=4, ADJ_TICKS=2.
// Expected digits are hand-computed mm:ss values packed as 16'hMMSS.
module tb_stopwatch_counter;

    logic       clk1KHz;
    logic       rst;
    logic       pause;
    logic       clear;
    logic       adj;
    logic       sel;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       running;
    logic       sec_tick;

    int checks;
    int failures;

    stopwatch_counter #(
        .TICKS_PER_SEC(4),
        .ADJ_TICKS    (2)
    ) dut (
        .clk1KHz (clk1KHz),
        .rst     (rst),
        .pause   (pause),
        .clear   (clear),
        .adj     (adj),
        .sel     (sel),
        .digit1  (digit1),
        .digit2  (digit2),
        .digit3  (digit3),
        .digit4  (digit4),
        .running (running),
        .sec_tick(sec_tick)
    );

    initial clk1KHz = 1'b0;
    always #5 clk1KHz = ~clk1KHz;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkDigits(input string tag, input logic [15:0] expected);
        checkOutput(tag, {16'h0, digit1, digit2, digit3, digit4}, {16'h0, expected});
    endtask

    // Advance n rising edges, then settle 1 ns past the last edge.
    task automatic tickCycles(input int n);
        if (n > 0) repeat (n) @(posedge clk1KHz);
        #1;
    endtask

    // Drive inputs for one sampling edge; pause and clear are single-cycle pulses.
    task automatic applyStimulus(input logic p, input logic c, input logic a, input logic s);
        pause = p;
        clear = c;
        adj   = a;
        sel   = s;
        tickCycles(1);
        pause = 1'b0;
        clear = 1'b0;
    endtask

    // Clear, then load mm:ss through ADJUST, leaving the counter STOPPED.
    task automatic setTime(input int mm, input int ss);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tickCycles(2 * mm);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        tickCycles(2 * ss);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        pause    = 1'b0;
        clear    = 1'b0;
        adj      = 1'b0;
        sel      = 1'b0;

        #2;
        checkDigits("reset_digits", 16'h0000);
        checkOutput("reset_running", {31'h0, running}, 32'd0);
        checkOutput("reset_sec_tick", {31'h0, sec_tick}, 32'd0);
        @(posedge clk1KHz);
        #1;
        rst = 1'b0;

        $display("[TB] start/first-second latency");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_running", {31'h0, running}, 32'd1);
        checkDigits("start_digits", 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            tickCycles(1);
            checkOutput("first_sec_tick", {31'h0, sec_tick}, (i == 4) ? 32'd1 : 32'd0);
            checkDigits("first_sec_digits", (i == 4) ? 16'h0001 : 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("stop_running", {31'h0, running}, 32'd0);
        checkOutput("stop_sec_tick", {31'h0, sec_tick}, 32'd0);
        checkDigits("stop_digits", 16'h0001);

        $display("[TB] carry from 00:58");
        setTime(0, 58);
        checkDigits("preload_0058", 16'h0058);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickCycles(4);
        checkDigits("run_0059", 16'h0059);
        tickCycles(4);
        checkDigits("run_0100", 16'h0100);
        tickCycles(4);
        checkDigits("run_0101", 16'h0101);
        checkOutput("run_0101_tick", {31'h0, sec_tick}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkDigits("stopped_0101", 16'h0101);

        $display("[TB] wrap from 59:59");
        setTime(59, 59);
        checkDigits("preload_5959", 16'h5959);
        checkOutput("preload_running", {31'h0, running}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickCycles(3);
        checkDigits("wrap_hold_5959", 16'h5959);
        tickCycles(1);
        checkDigits("wrap_0000", 16'h0000);
        checkOutput("wrap_tick", {31'h0, sec_tick}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] partial second discarded on pause");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("partial_stopped", {31'h0, running}, 32'd0);
        checkDigits("partial_digits", 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickCycles(3);
        checkDigits("resume_no_early", 16'h0000);
        tickCycles(1);
        checkDigits("resume_full_sec", 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] adjust mode");
        setTime(0, 58);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("adj_running", {31'h0, running}, 32'd0);
        tickCycles(2);
        checkDigits("adj_sec_0059", 16'h0059);
        checkOutput("adj_tick", {31'h0, sec_tick}, 32'd1);
        tickCycles(2);
        checkDigits("adj_sec_wrap_0000", 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkDigits("adj_sel_change", 16'h0000);
        tickCycles(2);
        checkDigits("adj_min_0100", 16'h0100);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("adj_pause_ignored", {31'h0, running}, 32'd0);
        checkDigits("adj_pause_digits", 16'h0100);
        tickCycles(1);
        checkDigits("adj_min_0200", 16'h0200);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tickCycles(4);
        checkDigits("adj_exit_hold", 16'h0200);
        checkOutput("adj_exit_running", {31'h0, running}, 32'd0);

        $display("[TB] clear beats pause; tick with pause");
        setTime(12, 34);
        checkDigits("preload_1234", 16'h1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkDigits("clear_digits", 16'h0000);
        checkOutput("clear_running", {31'h0, running}, 32'd0);
        checkOutput("clear_tick", {31'h0, sec_tick}, 32'd0);
        tickCycles(4);
        checkDigits("clear_hold", 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkDigits("tick_pause_digits", 16'h0001);
        checkOutput("tick_pause_tick", {31'h0, sec_tick}, 32'd1);
        checkOutput("tick_pause_running", {31'h0, running}, 32'd0);
        tickCycles(4);
        checkDigits("tick_pause_hold", 16'h0001);

        $display("[TB] asynchronous reset mid-second");
        setTime(3, 7);
        checkDigits("preload_0307", 16'h0307);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tickCycles(2);
        rst = 1'b1;
        #1;
        checkDigits("async_rst_digits", 16'h0000);
        checkOutput("async_rst_running", {31'h0, running}, 32'd0);
        tickCycles(1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tickCycles(1);
            checkOutput("post_rst_no_tick", {31'h0, sec_tick}, 32'd0);
        end
        checkDigits("post_rst_digits", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
